// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered N-to-2**N one-hot decoder with dwell-timed up/down scan; optional DECODER_SCAN_MASK_EN adds a position mask
module decoder_scan_n #(
  parameter int N = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [N-1:0]       sel,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_SCAN_MASK_EN
  input  logic [2**N-1:0]    mask,
`endif
  output logic [2**N-1:0]    f,
  output logic [N-1:0]       idx,
  output logic               wrap
);
  localparam int M = 2**N;
  logic [N-1:0] step, idx_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic step_wrap, adv, blank, wrap_d;
`ifdef DECODER_SCAN_MASK_EN
  logic [N-1:0] p;
  // nearest enabled position in the scan direction; the smallest distance is assigned last and wins
  always_comb begin
    step = idx;
    p = '0;
    for (int i = M - 1; i > 0; i--) begin
      p = dir ? idx - N'(i) : idx + N'(i);
      if (mask[p]) step = p;
    end
    step_wrap = dir ? step > idx : step < idx;
    blank = mode && mask == '0;
  end
`else
  // plain neighbour step with boundary detection
  always_comb begin
    step = dir ? idx - N'(1) : idx + N'(1);
    step_wrap = dir ? idx == '0 : &idx;
    blank = 1'b0;
  end
`endif
  // next index, dwell count and wrap pulse for an enabled cycle
  always_comb begin
    adv = mode && !load && cnt >= dwell;
    idx_d = (!mode || load) ? sel : adv ? step : idx;
    cnt_d = (!mode || load || adv) ? '0 : cnt + DWELL_W'(1);
    wrap_d = adv && step_wrap;
  end
  // state and registered decode; disable freezes idx/cnt and blanks the output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
      wrap <= 1'b0;
      f <= '0;
    end else if (!en) begin
      wrap <= 1'b0;
      f <= '0;
    end else begin
      idx <= idx_d;
      cnt <= cnt_d;
      wrap <= wrap_d;
      f <= blank ? '0 : M'(1) << idx_d;
    end
  end
endmodule

// File: tb/tb_decoder_scan_n.sv
// tb_decoder_scan_n: directed vectors for decoder_scan_n (N=3, DWELL_W=8)
module tb_decoder_scan_n;
  logic clk = 1'b0, rst_n, en, mode, load, dir, wrap;
  logic [2:0] sel, idx;
  logic [7:0] dwell, f;
  int vecs = 0, errs = 0;
`ifdef DECODER_SCAN_MASK_EN
  logic [7:0] mask = 8'hff;
`endif

  decoder_scan_n #(.N(3), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
    .dir(dir), .dwell(dwell),
`ifdef DECODER_SCAN_MASK_EN
    .mask(mask),
`endif
    .f(f), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [2:0] ei, input logic ew, input logic eon);
    check({tag, ".f"}, f, eon ? 8'h01 << ei : 8'h00);
    check({tag, ".idx"}, idx, ei);
    check({tag, ".wrap"}, wrap, ew);
  endtask

  initial begin
    rst_n = 0; en = 0; mode = 0; load = 0; sel = 0; dir = 0; dwell = 0;
    tick(); tick();
    expect_state("reset", 3'd0, 1'b0, 1'b0);
    rst_n = 1; en = 1; sel = 3'd5;
    tick();
    check("direct5", f, 8'b0010_0000);
    sel = 3'd7;
    tick();
    check("direct7", f, 8'b1000_0000);
    sel = 3'd3;
    tick();
    check("direct3", f, 8'b0000_1000);
    en = 0; sel = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("disabled", 3'd3, 1'b0, 1'b0);
    end
    en = 1; sel = 3'd3;
    tick();
    check("reenable", f, 8'b0000_1000);
    mode = 1; dir = 0; dwell = 8'd2; load = 1; sel = 3'd6;
    tick();
    load = 0;
    expect_state("up_load", 3'd6, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      expect_state("up_scan", i < 3 ? 3'd6 : i < 6 ? 3'd7 : 3'd0, i == 6, 1'b1);
    end
    dir = 1; dwell = 8'd0; load = 1; sel = 3'd1;
    tick();
    load = 0;
    check("down_load", f, 8'h02);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_state("down_scan", 3'(1 - i), i == 2, 1'b1);
    end
    dir = 0;
    tick();
    expect_state("dir_flip", 3'd6, 1'b0, 1'b1);
    dwell = 8'd4; load = 1; sel = 3'd4;
    tick();
    load = 0;
    tick(); tick();
    load = 1; sel = 3'd2;
    tick();
    load = 0;
    expect_state("midload", 3'd2, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("dwell5.idx", idx, i < 5 ? 3'd2 : 3'd3);
    end
    tick(); tick(); tick();
    dwell = 8'd1;
    tick();
    check("dwell_shrink", idx, 3'd4);
    dwell = 8'd2;
    tick();
    en = 0;
    tick(); tick();
    expect_state("scan_frozen", 3'd4, 1'b0, 1'b0);
    en = 1;
    tick();
    expect_state("scan_resume", 3'd4, 1'b0, 1'b1);
    tick();
    expect_state("resume_adv", 3'd5, 1'b0, 1'b1);
    mode = 0; sel = 3'd1;
    tick();
    expect_state("to_direct", 3'd1, 1'b0, 1'b1);
    mode = 1; dwell = 8'd4; load = 1; sel = 3'd7;
    tick();
    load = 0;
    tick();
    rst_n = 0;
    tick();
    expect_state("midreset", 3'd0, 1'b0, 1'b0);
    rst_n = 1;
`ifdef DECODER_SCAN_MASK_EN
    mask = 8'b1001_0010; dwell = 8'd0; dir = 0; load = 1; sel = 3'd1;
    tick();
    load = 0;
    check("mask_load", idx, 3'd1);
    tick();
    expect_state("mask_a", 3'd4, 1'b0, 1'b1);
    tick();
    expect_state("mask_b", 3'd7, 1'b0, 1'b1);
    tick();
    expect_state("mask_c", 3'd1, 1'b1, 1'b1);
    mask = 8'h00;
    tick();
    expect_state("mask_zero", 3'd1, 1'b0, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
